aurora_fc_ctrl_v2: RTL and testbench

AURORA_FC_CTRL_V2 -- requirements
Module: aurora_fc_ctrl_v2

---
 rtl/aurora_fc_ctrl_v2.sv | 123 ++++++++++++
 tb/tb_aurora_fc_ctrl_v2.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aurora_fc_ctrl_v2.sv
// Aurora native flow control (NFC) controller with an rx frame-integrity monitor.
// The FC FSM turns a level xoff_req into NFC XOFF/XON requests, re-issuing XOFF
// periodically while held. The monitor flags bad frames on tuser and counts them.
module aurora_fc_ctrl_v2 #(
  parameter int              NB_W      = 4,
  parameter logic [NB_W-1:0] XOFF_NB   = 4'hF,
  parameter logic [NB_W-1:0] XON_NB    = 4'h0,
  parameter int              REFRESH   = 256,
  parameter int              MAX_BEATS = 1024,
  parameter int              CNT_W     = 16
) (
  input  logic             user_clk,
  input  logic             aresetn,
  input  logic             channel_up,
  input  logic             xoff_req,
  output logic             nfc_req,
  output logic [NB_W-1:0]  nfc_nb,
  input  logic             nfc_ack,
  input  logic             rx_tvalid,
  input  logic             rx_tlast,
  input  logic             frame_err,
  output logic             rx_tuser,
  output logic             xoff_active,
  output logic [1:0]       fc_state,
  output logic [CNT_W-1:0] bad_frames
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ_XOFF = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] REQ_XON  = 2'd3;

  localparam int              RW       = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [RW-1:0]   REF_LAST = RW'((REFRESH == 0) ? 0 : REFRESH - 1);
  localparam int              BW       = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0]   BEAT_MAX = BW'(MAX_BEATS);

  logic [1:0]       state, state_nxt;
  logic [RW-1:0]    ref_cnt, ref_cnt_nxt;
  logic             in_frame, err_seen;
  logic [BW-1:0]    beat_cnt, beat_inc;
  logic [CNT_W-1:0] bad_inc;

  // FC next-state and refresh counter; channel loss overrides everything
  always_comb begin
    state_nxt   = state;
    ref_cnt_nxt = ref_cnt;
    if (!channel_up) begin
      state_nxt   = IDLE;
      ref_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE:     if (xoff_req) state_nxt = REQ_XOFF;
        REQ_XOFF: if (nfc_ack) begin
                    state_nxt   = HOLD;
                    ref_cnt_nxt = '0;
                  end
        HOLD: begin
          ref_cnt_nxt = ref_cnt + RW'(1);
          if (!xoff_req)
            state_nxt = REQ_XON;
          else if (REFRESH != 0 && ref_cnt == REF_LAST)
            state_nxt = REQ_XOFF;
        end
        default:  if (nfc_ack) state_nxt = IDLE;
      endcase
    end
  end

  // FSM state plus outputs registered from the next state so they align with it
  always_ff @(posedge user_clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      ref_cnt     <= '0;
      nfc_req     <= 1'b0;
      nfc_nb      <= XON_NB;
      xoff_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      ref_cnt     <= ref_cnt_nxt;
      nfc_req     <= (state_nxt == REQ_XOFF) || (state_nxt == REQ_XON);
      nfc_nb      <= (state_nxt == REQ_XOFF) ? XOFF_NB : XON_NB;
      xoff_active <= (state_nxt == HOLD);
    end
  end

  assign fc_state = state;

  // beat_cnt saturates at MAX_BEATS, so beat_cnt+1 > MAX_BEATS is beat_cnt == MAX_BEATS
  always_comb begin
    beat_inc = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + BW'(1);
    bad_inc  = (bad_frames == '1) ? bad_frames : bad_frames + CNT_W'(1);
    rx_tuser = aresetn & rx_tvalid & rx_tlast &
               (err_seen | frame_err | (beat_cnt == BEAT_MAX));
  end

  // rx frame monitor and saturating bad-frame counter
  always_ff @(posedge user_clk or negedge aresetn) begin
    if (!aresetn) begin
      in_frame   <= 1'b0;
      beat_cnt   <= '0;
      err_seen   <= 1'b0;
      bad_frames <= '0;
    end else if (!channel_up) begin
      if (in_frame) bad_frames <= bad_inc;
      in_frame <= 1'b0;
      beat_cnt <= '0;
      err_seen <= 1'b0;
    end else if (rx_tvalid && rx_tlast) begin
      if (rx_tuser) bad_frames <= bad_inc;
      in_frame <= 1'b0;
      beat_cnt <= '0;
      err_seen <= 1'b0;
    end else if (rx_tvalid) begin
      in_frame <= 1'b1;
      beat_cnt <= beat_inc;
      if (frame_err || beat_inc == BEAT_MAX) err_seen <= 1'b1;
    end else if (in_frame && frame_err) begin
      err_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aurora_fc_ctrl_v2.sv
// Directed bench for aurora_fc_ctrl_v2: FC handshake, refresh, channel drop,
// frame error flagging, counter saturation and asynchronous reset.
module tb_aurora_fc_ctrl_v2;

  logic       user_clk = 1'b0;
  logic       aresetn, channel_up, xoff_req, nfc_ack;
  logic       rx_tvalid, rx_tlast, frame_err;
  logic       nfc_req_a, rx_tuser_a, xoff_active_a;
  logic [3:0] nfc_nb_a;
  logic [1:0] fc_state_a, bad_frames_a;
  logic       nfc_req_b, rx_tuser_b, xoff_active_b;
  logic [3:0] nfc_nb_b;
  logic [1:0] fc_state_b;
  logic [15:0] bad_frames_b;
  int tests = 0;
  int failed = 0;

  always #5 user_clk = ~user_clk;

  aurora_fc_ctrl_v2 #(.REFRESH(8), .MAX_BEATS(4), .CNT_W(2)) dut_a (
    .user_clk(user_clk), .aresetn(aresetn), .channel_up(channel_up),
    .xoff_req(xoff_req), .nfc_req(nfc_req_a), .nfc_nb(nfc_nb_a),
    .nfc_ack(nfc_ack), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
    .frame_err(frame_err), .rx_tuser(rx_tuser_a), .xoff_active(xoff_active_a),
    .fc_state(fc_state_a), .bad_frames(bad_frames_a));

  aurora_fc_ctrl_v2 #(.REFRESH(0)) dut_b (
    .user_clk(user_clk), .aresetn(aresetn), .channel_up(channel_up),
    .xoff_req(xoff_req), .nfc_req(nfc_req_b), .nfc_nb(nfc_nb_b),
    .nfc_ack(nfc_ack), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
    .frame_err(frame_err), .rx_tuser(rx_tuser_b), .xoff_active(xoff_active_b),
    .fc_state(fc_state_b), .bad_frames(bad_frames_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  // drive one rx cycle, check tuser before the edge, then clock it in
  task automatic beat(input logic v, input logic l, input logic e,
                      input string tag, input logic exp_tuser);
    rx_tvalid = v; rx_tlast = l; frame_err = e;
    #1;
    if (v && l) chk(tag, 32'(rx_tuser_a), 32'(exp_tuser));
    tick();
    rx_tvalid = 1'b0; rx_tlast = 1'b0; frame_err = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; channel_up = 1'b0; xoff_req = 1'b0; nfc_ack = 1'b0;
    rx_tvalid = 1'b0; rx_tlast = 1'b0; frame_err = 1'b0;
    #3;
    chk("rst_nfc_req", 32'(nfc_req_a), 0);
    chk("rst_nfc_nb", 32'(nfc_nb_a), 0);
    chk("rst_xoff_active", 32'(xoff_active_a), 0);
    chk("rst_fc_state", 32'(fc_state_a), 0);
    chk("rst_bad_frames", 32'(bad_frames_a), 0);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // basic XOFF, ack after three request cycles
    channel_up = 1'b1; xoff_req = 1'b1;
    tick();
    chk("xoff_state", 32'(fc_state_a), 1);
    chk("xoff_req", 32'(nfc_req_a), 1);
    chk("xoff_nb", 32'(nfc_nb_a), 32'hF);
    tick();
    chk("xoff_stable_nb", 32'(nfc_nb_a), 32'hF);
    tick();
    nfc_ack = 1'b1;
    tick();
    nfc_ack = 1'b0;
    chk("hold_state", 32'(fc_state_a), 2);
    chk("hold_active", 32'(xoff_active_a), 1);
    chk("hold_req", 32'(nfc_req_a), 0);
    chk("hold_nb", 32'(nfc_nb_a), 0);

    // refresh: XOFF re-issued 8 cycles after ack (dut_a), never for dut_b
    repeat (7) tick();
    chk("refresh_early", 32'(nfc_req_a), 0);
    tick();
    chk("refresh_req", 32'(nfc_req_a), 1);
    chk("refresh_state", 32'(fc_state_a), 1);
    chk("refresh_nb", 32'(nfc_nb_a), 32'hF);
    chk("norefresh_state", 32'(fc_state_b), 2);
    chk("norefresh_req", 32'(nfc_req_b), 0);
    nfc_ack = 1'b1;
    tick();
    nfc_ack = 1'b0;
    chk("reack_state", 32'(fc_state_a), 2);

    // XON, with xoff_req reasserting mid-XON
    xoff_req = 1'b0;
    tick();
    chk("xon_state", 32'(fc_state_a), 3);
    chk("xon_req", 32'(nfc_req_a), 1);
    chk("xon_nb", 32'(nfc_nb_a), 0);
    chk("xon_active", 32'(xoff_active_a), 0);
    xoff_req = 1'b1;
    tick();
    chk("xon_not_aborted", 32'(fc_state_a), 3);
    nfc_ack = 1'b1;
    tick();
    nfc_ack = 1'b0;
    chk("xon_ack_idle", 32'(fc_state_a), 0);
    chk("xon_ack_req", 32'(nfc_req_a), 0);
    tick();
    chk("reenter_xoff", 32'(fc_state_a), 1);

    // channel drop during REQ_XOFF, then a late ack
    channel_up = 1'b0;
    tick();
    chk("drop_state", 32'(fc_state_a), 0);
    chk("drop_req", 32'(nfc_req_a), 0);
    channel_up = 1'b1; xoff_req = 1'b0; nfc_ack = 1'b1;
    tick();
    nfc_ack = 1'b0;
    chk("late_ack_state", 32'(fc_state_a), 0);
    chk("late_ack_active", 32'(xoff_active_a), 0);

    // frames with MAX_BEATS=4
    repeat (3) beat(1, 0, 0, "", 0);
    beat(1, 1, 0, "f4_tuser", 0);
    chk("f4_bad", 32'(bad_frames_a), 0);
    repeat (4) beat(1, 0, 0, "", 0);
    beat(1, 1, 0, "f5_tuser", 1);
    chk("f5_bad", 32'(bad_frames_a), 1);
    beat(1, 0, 0, "", 0);
    beat(1, 0, 1, "", 0);
    beat(1, 1, 0, "ferr_tuser", 1);
    chk("ferr_bad", 32'(bad_frames_a), 2);
    beat(1, 1, 0, "single_clean", 0);
    chk("single_clean_bad", 32'(bad_frames_a), 2);

    // channel drop mid-frame counts once and clears error state
    beat(1, 0, 1, "", 0);
    beat(1, 0, 0, "", 0);
    channel_up = 1'b0;
    tick();
    channel_up = 1'b1;
    chk("trunc_bad", 32'(bad_frames_a), 3);
    tick();
    chk("trunc_once", 32'(bad_frames_a), 3);
    beat(1, 1, 0, "post_trunc_clean", 0);

    // saturation: two more bad frames (five total) keep count at 3
    beat(1, 1, 1, "single_err1", 1);
    beat(1, 1, 1, "single_err2", 1);
    chk("sat_bad", 32'(bad_frames_a), 3);

    // async reset mid-frame and mid-REQ_XON
    xoff_req = 1'b1;
    tick();
    nfc_ack = 1'b1;
    tick();
    nfc_ack = 1'b0; xoff_req = 1'b0;
    tick();
    chk("pre_rst_xon", 32'(fc_state_a), 3);
    beat(1, 0, 0, "", 0);
    rx_tvalid = 1'b1; rx_tlast = 1'b1; frame_err = 1'b1;
    #1;
    chk("pre_rst_tuser", 32'(rx_tuser_a), 1);
    #1;
    aresetn = 1'b0;
    #1;
    chk("arst_nfc_req", 32'(nfc_req_a), 0);
    chk("arst_nfc_nb", 32'(nfc_nb_a), 0);
    chk("arst_active", 32'(xoff_active_a), 0);
    chk("arst_state", 32'(fc_state_a), 0);
    chk("arst_bad", 32'(bad_frames_a), 0);
    chk("arst_tuser", 32'(rx_tuser_a), 0);
    rx_tvalid = 1'b0; rx_tlast = 1'b0; frame_err = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    beat(1, 1, 0, "post_rst_clean", 0);
    chk("post_rst_bad", 32'(bad_frames_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
